// File: rtl/uart_tx_scheduler_if.sv
// Signal bundle between the UART TX scheduler, its read-side FIFO and the transmitter.
// master is the scheduler's view; slave is the FIFO/transmitter environment's view.
interface uart_tx_scheduler_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  enable_i;
    logic                  clr_req_i;
    logic [DATA_WIDTH-1:0] fifo_data_i;
    logic                  fifo_empty_i;
    logic                  fifo_n_re_o;
    logic                  fifo_n_clr_o;
    logic [DATA_WIDTH-1:0] tx_data_o;
    logic                  tx_start_o;
    logic                  tx_done_i;
    logic                  busy_o;
    logic [15:0]           frame_cnt_o;
    logic                  err_timeout_o;

    modport master (
        input  enable_i, clr_req_i, fifo_data_i, fifo_empty_i, tx_done_i,
        output fifo_n_re_o, fifo_n_clr_o, tx_data_o, tx_start_o, busy_o,
        frame_cnt_o, err_timeout_o
    );

    modport slave (
        output enable_i, clr_req_i, fifo_data_i, fifo_empty_i, tx_done_i,
        input  fifo_n_re_o, fifo_n_clr_o, tx_data_o, tx_start_o, busy_o,
        frame_cnt_o, err_timeout_o
    );
endinterface

// File: rtl/uart_tx_scheduler.sv
// Pulls bytes from a registered-output FIFO and hands them to a UART transmitter,
// with an inter-frame gap, a transmitter watchdog and a flush/abort path.
module uart_tx_scheduler #(
    parameter int DATA_WIDTH     = 8,
    parameter int GAP_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                    clk,
    input  logic                    rst,
    uart_tx_scheduler_if.master     bus
);
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_READ      = 3'd1,
        ST_WAIT_DATA = 3'd2,
        ST_LOAD      = 3'd3,
        ST_WAIT_TX   = 3'd4,
        ST_GAP       = 3'd5,
        ST_CLEAR     = 3'd6
    } state_t;

    // Counters hold "cycles remaining minus one" so the terminal test is a compare to a constant.
    localparam logic [15:0] GAP_LOAD     = 16'(GAP_CYCLES - 1);
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t                state_r;
    logic [15:0]           wdog_r;
    logic [15:0]           gap_cnt_r;
    logic [15:0]           frame_cnt_r;
    logic                  err_timeout_r;
    logic [DATA_WIDTH-1:0] tx_data_r;

    // Scheduler FSM with its watchdog, gap counter, data and status registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r       <= ST_IDLE;
            wdog_r        <= 16'd0;
            gap_cnt_r     <= 16'd0;
            frame_cnt_r   <= 16'd0;
            err_timeout_r <= 1'b0;
            tx_data_r     <= '0;
        end else if (bus.clr_req_i && (state_r != ST_CLEAR)) begin
            state_r <= ST_CLEAR;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.enable_i && !bus.fifo_empty_i) begin
                        state_r <= ST_READ;
                    end
                end
                ST_READ: begin
                    state_r <= ST_WAIT_DATA;
                end
                ST_WAIT_DATA: begin
                    tx_data_r <= bus.fifo_data_i;
                    state_r   <= ST_LOAD;
                end
                ST_LOAD: begin
                    wdog_r  <= 16'd0;
                    state_r <= ST_WAIT_TX;
                end
                ST_WAIT_TX: begin
                    // A done pulse in the same cycle as the timeout wins.
                    if (bus.tx_done_i) begin
                        frame_cnt_r <= frame_cnt_r + 16'd1;
                        gap_cnt_r   <= GAP_LOAD;
                        state_r     <= ST_GAP;
                    end else if (wdog_r == TIMEOUT_LAST) begin
                        err_timeout_r <= 1'b1;
                        gap_cnt_r     <= GAP_LOAD;
                        state_r       <= ST_GAP;
                    end else begin
                        wdog_r <= wdog_r + 16'd1;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_r == 16'd0) begin
                        state_r <= ST_IDLE;
                    end else begin
                        gap_cnt_r <= gap_cnt_r - 16'd1;
                    end
                end
                ST_CLEAR: begin
                    err_timeout_r <= 1'b0;
                    state_r       <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.fifo_n_re_o   = (state_r != ST_READ);
    assign bus.fifo_n_clr_o  = (state_r != ST_CLEAR);
    assign bus.tx_start_o    = (state_r == ST_LOAD);
    assign bus.busy_o        = (state_r != ST_IDLE);
    assign bus.tx_data_o     = tx_data_r;
    assign bus.frame_cnt_o   = frame_cnt_r;
    assign bus.err_timeout_o = err_timeout_r;
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench: behavioural FIFO and transmitter around two scheduler instances
// (long and short watchdog); expected start times derive from the frame timing rules.
module tb_uart_tx_scheduler;
    localparam int DW       = 8;
    localparam int GAP      = 16;
    localparam int TO_MAIN  = 4096;
    localparam int TO_SHORT = 8;

    typedef struct packed {
        int         cyc;
        logic [7:0] data;
    } start_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   exp_frames = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_scheduler_if #(.DATA_WIDTH(DW)) bus ();
    uart_tx_scheduler_if #(.DATA_WIDTH(DW)) bus_to ();

    uart_tx_scheduler #(.DATA_WIDTH(DW), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO_MAIN)) u_dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    uart_tx_scheduler #(.DATA_WIDTH(DW), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO_SHORT)) u_dut_to (
        .clk(clk), .rst(rst), .bus(bus_to)
    );

    // Behavioural FIFOs: contents are push_mem[rd .. wr-1]; pops/clears act mid-cycle.
    logic [7:0] push_mem [0:63];
    int         push_wr = 0;
    int         fifo_rd = 0;
    logic [7:0] push_mem_to [0:63];
    int         push_wr_to = 0;
    int         fifo_rd_to = 0;

    assign bus.fifo_empty_i    = (fifo_rd == push_wr);
    assign bus_to.fifo_empty_i = (fifo_rd_to == push_wr_to);
    assign bus_to.tx_done_i    = 1'b0;

    always @(negedge clk) begin
        if (!bus.fifo_n_clr_o) begin
            fifo_rd <= push_wr;
        end else if (!bus.fifo_n_re_o && (fifo_rd != push_wr)) begin
            bus.fifo_data_i <= push_mem[fifo_rd];
            fifo_rd         <= fifo_rd + 1;
        end
    end

    always @(negedge clk) begin
        if (!bus_to.fifo_n_clr_o) begin
            fifo_rd_to <= push_wr_to;
        end else if (!bus_to.fifo_n_re_o && (fifo_rd_to != push_wr_to)) begin
            bus_to.fifo_data_i <= push_mem_to[fifo_rd_to];
            fifo_rd_to         <= fifo_rd_to + 1;
        end
    end

    // Transmitter model: pulses tx_done_i done_delay cycles after each start.
    int done_delay = 10;
    int done_timer = 0;
    always @(negedge clk) begin
        bus.tx_done_i <= 1'b0;
        if (done_timer > 0) begin
            done_timer <= done_timer - 1;
            if (done_timer == 1) bus.tx_done_i <= 1'b1;
        end
        if (bus.tx_start_o) done_timer <= done_delay;
    end

    // Event recorders.
    start_t starts[$];
    start_t starts_to[$];
    int     nre_cnt = 0;
    int     nclr_cnt = 0;
    always @(negedge clk) begin
        if (bus.tx_start_o) starts.push_back('{cyc, bus.tx_data_o});
        if (bus_to.tx_start_o) starts_to.push_back('{cyc, bus_to.tx_data_o});
        if (!bus.fifo_n_re_o) nre_cnt <= nre_cnt + 1;
        if (!bus.fifo_n_clr_o) nclr_cnt <= nclr_cnt + 1;
    end

    task automatic push(input logic [7:0] b);
        push_mem[push_wr] = b;
        push_wr = push_wr + 1;
    endtask

    task automatic push_to(input logic [7:0] b);
        push_mem_to[push_wr_to] = b;
        push_wr_to = push_wr_to + 1;
    endtask

    // Park at the falling edge inside cycle c (always advances at least one edge).
    task automatic goto_neg(input int c);
        @(negedge clk);
        while (cyc < c) @(negedge clk);
    endtask

    // Park just after the rising edge that starts cycle c.
    task automatic goto_pos(input int c);
        do begin
            @(posedge clk);
            #1;
        end while (cyc < c);
    endtask

    task automatic test_reset();
        logic [28:0] exp_v;
        exp_v = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00};
        @(negedge clk);
        checks++;
        if ({bus.fifo_n_re_o, bus.fifo_n_clr_o, bus.tx_start_o, bus.busy_o, bus.err_timeout_o,
             bus.frame_cnt_o, bus.tx_data_o} !== exp_v) begin
            errors++;
            $display("FAIL reset_main: got %h want %h", {bus.fifo_n_re_o, bus.fifo_n_clr_o,
                     bus.tx_start_o, bus.busy_o, bus.err_timeout_o, bus.frame_cnt_o, bus.tx_data_o}, exp_v);
        end
        checks++;
        if ({bus_to.fifo_n_re_o, bus_to.fifo_n_clr_o, bus_to.tx_start_o, bus_to.busy_o,
             bus_to.err_timeout_o, bus_to.frame_cnt_o, bus_to.tx_data_o} !== exp_v) begin
            errors++;
            $display("FAIL reset_to: busy %b err %b cnt %h", bus_to.busy_o, bus_to.err_timeout_o,
                     bus_to.frame_cnt_o);
        end
    endtask

    task automatic test_single(input int d, input logic [7:0] b);
        int p, s, e, base_s, base_nre, got_c;
        logic [7:0] got_d;
        done_delay = d;
        base_s = starts.size();
        base_nre = nre_cnt;
        goto_pos(cyc + 1);
        p = cyc;
        push(b);
        bus.enable_i = 1'b1;
        exp_frames++;
        s = p + 3;
        e = s + d + GAP + 1;
        goto_neg(p + 1);
        checks++;
        if (bus.fifo_n_re_o !== 1'b0) begin
            errors++;
            $display("FAIL single_n_re: got %b want 0 at cycle %0d", bus.fifo_n_re_o, p + 1);
        end
        goto_neg(e - 1);
        checks++;
        if (bus.busy_o !== 1'b1) begin
            errors++;
            $display("FAIL single_gap_busy: got %b want 1", bus.busy_o);
        end
        goto_neg(e);
        checks++;
        if (bus.busy_o !== 1'b0) begin
            errors++;
            $display("FAIL single_idle: got busy %b want 0", bus.busy_o);
        end
        got_c = (starts.size() > base_s) ? starts[base_s].cyc : -1;
        got_d = (starts.size() > base_s) ? starts[base_s].data : 8'hxx;
        checks++;
        if (starts.size() != base_s + 1 || got_c != s || got_d !== b) begin
            errors++;
            $display("FAIL single_start: got n=%0d cyc %0d data %h want n=1 cyc %0d data %h",
                     starts.size() - base_s, got_c, got_d, s, b);
        end
        checks++;
        if (nre_cnt != base_nre + 1) begin
            errors++;
            $display("FAIL single_n_re_count: got %0d want 1", nre_cnt - base_nre);
        end
        checks++;
        if (bus.frame_cnt_o !== 16'(exp_frames)) begin
            errors++;
            $display("FAIL single_frames: got %0d want %0d", bus.frame_cnt_o, exp_frames);
        end
        bus.enable_i = 1'b0;
    endtask

    task automatic test_burst(input int n, input int d, input bit fixed);
        logic [7:0] bytes[$];
        logic [7:0] b;
        int p, base_s, exp_c, e;
        done_delay = d;
        base_s = starts.size();
        goto_pos(cyc + 1);
        p = cyc;
        for (int k = 0; k < n; k++) begin
            b = fixed ? 8'(k + 1) : 8'($urandom);
            bytes.push_back(b);
            push(b);
        end
        bus.enable_i = 1'b1;
        exp_frames += n;
        e = p + 3 + (n - 1) * (d + GAP + 4) + d + GAP + 1;
        goto_neg(e);
        for (int k = 0; k < n; k++) begin
            exp_c = p + 3 + k * (d + GAP + 4);
            checks++;
            if (starts.size() <= base_s + k || starts[base_s + k].cyc != exp_c ||
                starts[base_s + k].data !== bytes[k]) begin
                errors++;
                $display("FAIL burst_start[%0d]: got n=%0d, want cyc %0d data %h", k,
                         starts.size() - base_s, exp_c, bytes[k]);
            end
        end
        checks++;
        if (bus.frame_cnt_o !== 16'(exp_frames) || starts.size() != base_s + n) begin
            errors++;
            $display("FAIL burst_frames: got cnt %0d starts %0d want cnt %0d starts %0d",
                     bus.frame_cnt_o, starts.size() - base_s, exp_frames, n);
        end
        checks++;
        if ({bus.fifo_empty_i, bus.busy_o} !== 2'b10) begin
            errors++;
            $display("FAIL burst_end: got empty %b busy %b want 1 0", bus.fifo_empty_i, bus.busy_o);
        end
        bus.enable_i = 1'b0;
    endtask

    task automatic test_disable();
        int d, p, s0, q, s1, base_s, base_nre;
        logic [7:0] b0, b1;
        d = $urandom_range(8, 2);
        done_delay = d;
        b0 = 8'($urandom);
        b1 = 8'($urandom);
        base_s = starts.size();
        base_nre = nre_cnt;
        goto_pos(cyc + 1);
        p = cyc;
        push(b0);
        push(b1);
        bus.enable_i = 1'b1;
        s0 = p + 3;
        goto_pos(s0 + 1);
        bus.enable_i = 1'b0;
        exp_frames++;
        goto_neg(s0 + d + GAP + 41);
        checks++;
        if (starts.size() != base_s + 1 || nre_cnt != base_nre + 1) begin
            errors++;
            $display("FAIL disable_hold: got starts %0d reads %0d want 1 1",
                     starts.size() - base_s, nre_cnt - base_nre);
        end
        checks++;
        if ({bus.busy_o, bus.fifo_empty_i, bus.frame_cnt_o} !== {2'b00, 16'(exp_frames)}) begin
            errors++;
            $display("FAIL disable_state: got busy %b empty %b cnt %0d want 0 0 %0d",
                     bus.busy_o, bus.fifo_empty_i, bus.frame_cnt_o, exp_frames);
        end
        goto_pos(cyc + 1);
        q = cyc;
        bus.enable_i = 1'b1;
        s1 = q + 3;
        exp_frames++;
        goto_neg(s1 + d + GAP + 1);
        checks++;
        if (starts.size() != base_s + 2 || starts[base_s + 1].cyc != s1 ||
            starts[base_s + 1].data !== b1) begin
            errors++;
            $display("FAIL disable_resume: got n=%0d want 2, second start cyc %0d data %h",
                     starts.size() - base_s, s1, b1);
        end
        checks++;
        if (bus.frame_cnt_o !== 16'(exp_frames)) begin
            errors++;
            $display("FAIL disable_frames: got %0d want %0d", bus.frame_cnt_o, exp_frames);
        end
        bus.enable_i = 1'b0;
    endtask

    task automatic test_clear();
        int p, s0, base_s, base_clr;
        logic [7:0] b0;
        done_delay = 10;
        b0 = 8'($urandom);
        base_s = starts.size();
        base_clr = nclr_cnt;
        goto_pos(cyc + 1);
        p = cyc;
        push(b0);
        push(8'($urandom));
        push(8'($urandom));
        bus.enable_i = 1'b1;
        s0 = p + 3;
        goto_pos(s0 + 2);
        bus.clr_req_i = 1'b1;
        goto_neg(s0 + 3);
        checks++;
        if ({bus.fifo_n_clr_o, bus.busy_o} !== 2'b01) begin
            errors++;
            $display("FAIL clear_pulse: got n_clr %b busy %b want 0 1", bus.fifo_n_clr_o, bus.busy_o);
        end
        goto_pos(s0 + 4);
        bus.clr_req_i = 1'b0;
        goto_neg(s0 + 4);
        checks++;
        if ({bus.fifo_n_clr_o, bus.busy_o} !== 2'b10) begin
            errors++;
            $display("FAIL clear_exit: got n_clr %b busy %b want 1 0", bus.fifo_n_clr_o, bus.busy_o);
        end
        goto_neg(s0 + 30);
        checks++;
        if (nclr_cnt != base_clr + 1 || starts.size() != base_s + 1) begin
            errors++;
            $display("FAIL clear_counts: got clears %0d starts %0d want 1 1",
                     nclr_cnt - base_clr, starts.size() - base_s);
        end
        checks++;
        if ({bus.busy_o, bus.fifo_empty_i, bus.err_timeout_o, bus.frame_cnt_o, bus.tx_data_o} !==
            {3'b010, 16'(exp_frames), b0}) begin
            errors++;
            $display("FAIL clear_state: got busy %b empty %b err %b cnt %0d data %h want 0 1 0 %0d %h",
                     bus.busy_o, bus.fifo_empty_i, bus.err_timeout_o, bus.frame_cnt_o,
                     bus.tx_data_o, exp_frames, b0);
        end
        bus.enable_i = 1'b0;
    endtask

    task automatic test_timeout();
        int p, s0, s1;
        logic [7:0] b0, b1;
        b0 = 8'($urandom);
        b1 = 8'($urandom);
        goto_pos(cyc + 1);
        p = cyc;
        push_to(b0);
        push_to(b1);
        bus_to.enable_i = 1'b1;
        s0 = p + 3;
        s1 = s0 + TO_SHORT + 1 + GAP + 3;
        goto_neg(s0 + TO_SHORT);
        checks++;
        if (bus_to.err_timeout_o !== 1'b0) begin
            errors++;
            $display("FAIL timeout_early: got err %b want 0", bus_to.err_timeout_o);
        end
        goto_neg(s0 + TO_SHORT + 1);
        checks++;
        if ({bus_to.err_timeout_o, bus_to.busy_o, bus_to.frame_cnt_o} !== {2'b11, 16'h0000}) begin
            errors++;
            $display("FAIL timeout_flag: got err %b busy %b cnt %0d want 1 1 0",
                     bus_to.err_timeout_o, bus_to.busy_o, bus_to.frame_cnt_o);
        end
        goto_pos(s1 + 2);
        bus_to.clr_req_i = 1'b1;
        goto_pos(s1 + 3);
        bus_to.clr_req_i = 1'b0;
        goto_neg(s1 + 3);
        checks++;
        if (bus_to.fifo_n_clr_o !== 1'b0) begin
            errors++;
            $display("FAIL timeout_clear_pulse: got n_clr %b want 0", bus_to.fifo_n_clr_o);
        end
        goto_neg(s1 + 20);
        checks++;
        if (starts_to.size() != 2 || starts_to[0].cyc != s0 || starts_to[0].data !== b0 ||
            starts_to[1].cyc != s1 || starts_to[1].data !== b1) begin
            errors++;
            $display("FAIL timeout_starts: got n=%0d want 2 at cyc %0d/%0d data %h/%h",
                     starts_to.size(), s0, s1, b0, b1);
        end
        checks++;
        if ({bus_to.err_timeout_o, bus_to.busy_o, bus_to.frame_cnt_o} !== {2'b00, 16'h0000}) begin
            errors++;
            $display("FAIL timeout_after_clear: got err %b busy %b cnt %0d want 0 0 0",
                     bus_to.err_timeout_o, bus_to.busy_o, bus_to.frame_cnt_o);
        end
        bus_to.enable_i = 1'b0;
    endtask

    task automatic test_reset_mid();
        int p, q, s, base_s;
        logic [7:0] b;
        logic [28:0] exp_v;
        exp_v = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00};
        done_delay = 5;
        base_s = starts.size();
        goto_pos(cyc + 1);
        p = cyc;
        push(8'($urandom));
        bus.enable_i = 1'b1;
        goto_pos(p + 3);
        rst = 1'b0;
        goto_neg(p + 4);
        checks++;
        if ({bus.fifo_n_re_o, bus.fifo_n_clr_o, bus.tx_start_o, bus.busy_o, bus.err_timeout_o,
             bus.frame_cnt_o, bus.tx_data_o} !== exp_v) begin
            errors++;
            $display("FAIL reset_mid: got busy %b start %b cnt %0d data %h want all reset values",
                     bus.busy_o, bus.tx_start_o, bus.frame_cnt_o, bus.tx_data_o);
        end
        goto_pos(p + 5);
        rst = 1'b1;
        exp_frames = 0;
        goto_neg(p + 18);
        checks++;
        if (starts.size() != base_s + 1 || bus.busy_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_quiet: got starts %0d busy %b want 1 0",
                     starts.size() - base_s, bus.busy_o);
        end
        goto_pos(cyc + 1);
        q = cyc;
        b = 8'($urandom);
        push(b);
        s = q + 3;
        exp_frames++;
        goto_neg(s + 5 + GAP + 1);
        checks++;
        if (starts.size() != base_s + 2 || starts[base_s + 1].cyc != s ||
            starts[base_s + 1].data !== b || bus.frame_cnt_o !== 16'(exp_frames)) begin
            errors++;
            $display("FAIL reset_mid_restart: got starts %0d cnt %0d want 2 %0d (cyc %0d data %h)",
                     starts.size() - base_s, bus.frame_cnt_o, exp_frames, s, b);
        end
        bus.enable_i = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        bus.enable_i = 1'b0;
        bus.clr_req_i = 1'b0;
        bus_to.enable_i = 1'b0;
        bus_to.clr_req_i = 1'b0;
        repeat (3) @(posedge clk);
        test_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        test_single(10, 8'hA5);
        test_single(1, 8'($urandom));
        test_burst(3, 10, 1'b1);
        test_burst($urandom_range(5, 2), $urandom_range(20, 1), 1'b0);
        test_disable();
        test_clear();
        test_timeout();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
